huffman_decoder: RTL and testbench

Bit-serial prefix-code decoder that drains 32-bit packed code words from the Huffman coder's output FIFO and reconstructs the 3-bit symbol stream. It is the read-side consumer of that FIFO. It drives the FIFO `rd` strobe, samples the show-ahead `data_out` word, and emits one symbol per valid/ready handshake. A frame is a host-specified number of symbols; padding bits after the last symbol in the final word are discarded.

---
 rtl/huffman_decoder.sv | 107 ++++++++++
 tb/tb_huffman_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - bit-serial prefix-code decoder draining packed words from a show-ahead FIFO
// Optional bits_used counter enabled by defining HUFF_DEC_BITCNT_EN.
module huffman_decoder #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_symbols,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [2:0]        sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [31:0]       bits_used
);

  localparam int BL_W = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EMIT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [BL_W-1:0]   bits_left;
  logic [2:0]        ones;
  logic [CNT_W-1:0]  remaining;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sym_valid = (state == EMIT);
  assign fifo_rd   = (state == FETCH) & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      ones      <= '0;
      remaining <= '0;
      sym_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= num_symbols;
            ones      <= '0;
            bits_left <= '0;
            state     <= (num_symbols == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            shreg     <= fifo_data;
            bits_left <= BL_W'(WORD_W);
            state     <= DECODE;
          end
        end
        DECODE: begin
          shreg     <= shreg << 1;
          bits_left <= bits_left - 1'b1;
          if (!shreg[WORD_W-1]) begin
            sym_out <= ones;
            ones    <= '0;
            state   <= EMIT;
          end else if (ones == 3'd6) begin
            sym_out <= 3'd7;
            ones    <= '0;
            state   <= EMIT;
          end else begin
            ones <= ones + 1'b1;
            // A partial code at the end of a word continues in the next one.
            if (bits_left == BL_W'(1)) state <= FETCH;
          end
        end
        EMIT: begin
          if (sym_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1))  state <= DONE;
            else if (bits_left == '0)    state <= FETCH;
            else                         state <= DECODE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HUFF_DEC_BITCNT_EN
  logic [31:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        bit_cnt <= '0;
    else if (state == IDLE && start)   bit_cnt <= '0;
    else if (state == DECODE)          bit_cnt <= bit_cnt + 32'd1;
  end

  assign bits_used = bit_cnt;
`else
  assign bits_used = '0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - directed bench for huffman_decoder with a queue-backed show-ahead FIFO
module tb_huffman_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_symbols;
  logic        busy, done, fifo_rd, sym_valid, sym_ready;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [2:0]  sym_out;
  logic [31:0] bits_used;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] q[$];
  logic [2:0]  syms[$];
  int          pops, dones;
  logic        pop_now;
  logic [31:0] bu_hold;
  int          zeros;

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_symbols(num_symbols),
    .busy(busy), .done(done), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .bits_used(bits_used)
  );

  function automatic logic [31:0] bu_exp(input logic [31:0] n);
`ifdef HUFF_DEC_BITCNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? 32'd0 : q[0];
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    sync_fifo();
  endtask

  // One clock: observe at the falling edge, then apply the FIFO pop just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (sym_valid && sym_ready) syms.push_back(sym_out);
    if (fifo_rd) pops++;
    if (done) dones++;
    pop_now = fifo_rd;
    @(posedge clk);
    #1;
    if (pop_now && q.size() > 0) q.delete(0);
    sync_fifo();
  endtask

  task automatic begin_frame(input logic [15:0] n);
    syms.delete();
    pops = 0;
    dones = 0;
    num_symbols = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int budget;
    budget = 0;
    while (dones == 0 && budget < 500) begin
      step();
      budget++;
    end
    if (dones == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  task automatic check_case1(input string tag);
    check({tag, "_count"}, syms.size(), 32'd4);
    if (syms.size() == 4) begin
      check({tag, "_s0"}, syms[0], 3'd0);
      check({tag, "_s1"}, syms[1], 3'd1);
      check({tag, "_s2"}, syms[2], 3'd3);
      check({tag, "_s3"}, syms[3], 3'd0);
    end
    check({tag, "_pops"}, pops, 32'd1);
    check({tag, "_dones"}, dones, 32'd1);
    check({tag, "_bits_used"}, bits_used, bu_exp(32'd8));
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_symbols = '0;
    sym_ready = 1'b1;
    pops = 0;
    dones = 0;
    sync_fifo();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_sym_valid", sym_valid, 1'b0);
    check("rst_sym_out", sym_out, 3'd0);
    check("rst_bits_used", bits_used, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Case 1 with cycle-accurate latency checks.
    push(32'h5C00_0000);
    begin_frame(16'd4);
    check("c1_fetch_busy", busy, 1'b1);
    check("c1_fetch_rd", fifo_rd, 1'b1);
    step();
    check("c1_decode_valid", sym_valid, 1'b0);
    check("c1_decode_rd", fifo_rd, 1'b0);
    step();
    check("c1_emit_valid", sym_valid, 1'b1);
    check("c1_emit_sym", sym_out, 3'd0);
    run_to_done("c1");
    check_case1("c1");

    // Case 2: code spanning words with the FIFO running dry in between.
    push(32'h0000_0003);
    begin_frame(16'd31);
    for (int i = 0; i < 500 && syms.size() < 30; i++) step();
    for (int i = 0; i < 10; i++) step();
    check("c2_stall_busy", busy, 1'b1);
    check("c2_stall_rd", fifo_rd, 1'b0);
    check("c2_stall_valid", sym_valid, 1'b0);
    check("c2_stall_pops", pops, 32'd1);
    push(32'hC000_0000);
    run_to_done("c2");
    check("c2_count", syms.size(), 32'd31);
    zeros = 0;
    for (int i = 0; i < 30 && i < syms.size(); i++) if (syms[i] == 3'd0) zeros++;
    check("c2_zeros", zeros, 32'd30);
    if (syms.size() == 31) check("c2_last", syms[30], 3'd4);
    check("c2_pops", pops, 32'd2);
    check("c2_bits_used", bits_used, bu_exp(32'd35));

    // Case 3: longest code, with a start pulse while busy.
    push(32'hFE00_0000);
    begin_frame(16'd2);
    step();
    start = 1'b1;
    num_symbols = 16'd5;
    step();
    start = 1'b0;
    run_to_done("c3");
    check("c3_count", syms.size(), 32'd2);
    if (syms.size() == 2) begin
      check("c3_s0", syms[0], 3'd7);
      check("c3_s1", syms[1], 3'd0);
    end
    check("c3_dones", dones, 32'd1);
    check("c3_pops", pops, 32'd1);
    check("c3_bits_used", bits_used, bu_exp(32'd8));

    // Case 4: backpressure on the second symbol.
    push(32'h5C00_0000);
    begin_frame(16'd4);
    for (int i = 0; i < 100 && !(sym_valid && syms.size() == 1); i++) step();
    sym_ready = 1'b0;
    bu_hold = bits_used;
    for (int i = 0; i < 5; i++) begin
      step();
      check("c4_hold_valid", sym_valid, 1'b1);
      check("c4_hold_sym", sym_out, 3'd1);
      check("c4_hold_bits", bits_used, bu_hold);
    end
    sym_ready = 1'b1;
    run_to_done("c4");
    check_case1("c4");

    // Case 5: empty frame must not touch the FIFO.
    push(32'hFFFF_FFFF);
    begin_frame(16'd0);
    check("c5_done", done, 1'b1);
    check("c5_busy", busy, 1'b1);
    check("c5_rd", fifo_rd, 1'b0);
    step();
    check("c5_done_clear", done, 1'b0);
    check("c5_busy_after", busy, 1'b0);
    check("c5_pops", pops, 32'd0);
    q.delete();
    sync_fifo();

    // Case 6: reset in the middle of decoding, then a clean frame.
    push(32'h0000_0003);
    begin_frame(16'd31);
    for (int i = 0; i < 5; i++) step();
    check("c6_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("c6_rst_busy", busy, 1'b0);
    check("c6_rst_valid", sym_valid, 1'b0);
    check("c6_rst_rd", fifo_rd, 1'b0);
    check("c6_rst_sym", sym_out, 3'd0);
    check("c6_rst_bits", bits_used, 32'd0);
    pops = 0;
    push(32'h1234_5678);
    step();
    step();
    check("c6_rst_pops", pops, 32'd0);
    rst_n = 1'b1;
    q.delete();
    sync_fifo();
    step();
    push(32'h5C00_0000);
    begin_frame(16'd4);
    run_to_done("c6");
    check_case1("c6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
